// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the shift/add multiplier.
// Operand width is tied to the 8-bit adder; product is 2*WIDTH bits.
package shift_add_multiplier_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake bundle between a controller and the multiplier.
// The master issues operands and start; the slave returns product, busy and done.
interface shift_add_multiplier_if;
    import shift_add_multiplier_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     P;
    logic                   busy;
    logic                   done;

    modport master (output start, A, B, input P, busy, done);
    modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/eight_bit_adder.sv
// 8-bit ripple adder with carry in/out; purely combinational, zero latency.
// No flow control: R and C_out follow the inputs in the same cycle.
module eight_bit_adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       C_in,
    output logic [7:0] R,
    output logic       C_out
);

    logic [8:0] carry;

    always_comb begin
        carry[0] = C_in;
        for (int i = 0; i < 8; i++) begin
            R[i]         = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        C_out = carry[8];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier, one add/shift per cycle: done pulses the cycle after
// the 8th iteration (9 cycles after start), issue interval 10; start is ignored unless IDLE.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    shift_add_multiplier_if.slave   bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic [CNT_W-1:0]       count;
    logic [2*WIDTH-1:0]     p_q;

    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       sum;
    logic                   c_out;
    logic                   last_iter;
    logic [2*WIDTH-1:0]     hilo_nxt;

    // Multiplier LSB gates the multiplicand into the adder each iteration.
    assign addend    = lo[0] ? mcand : '0;
    assign last_iter = (count == CNT_W'(ITER - 1));
    assign hilo_nxt  = {c_out, sum, lo[WIDTH-1:1]};

    eight_bit_adder u_adder (
        .A     (hi),
        .B     (addend),
        .C_in  (1'b0),
        .R     (sum),
        .C_out (c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            p_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.A;
                        lo    <= bus.B;
                        hi    <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    // Carry out lands in hi[7] so no product bit is lost.
                    {hi, lo} <= hilo_nxt;
                    count    <= count + CNT_W'(1);
                    if (last_iter) begin
                        p_q <= hilo_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.P = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: stimulus pushes expected product and due cycle, a negedge monitor checks each done.
module tb_shift_add_multiplier;

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    shift_add_multiplier_if dif ();

    shift_add_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dif.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 with P=0x%0h, required no done at cycle %0d",
                         dif.P, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", 32'(dif.P), 32'(e.p));
                check("done_latency_cycle", 32'(cyc), 32'(e.due));
                check("busy_low_on_done", 32'(dif.busy), 32'd0);
            end
        end
    end

    // Issue one multiply from IDLE, count busy cycles, return on the done cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p_exp);
        int bc;
        @(negedge clk);
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{p: p_exp, due: cyc + 8});
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                dif.start = 1'b0;
                dif.A     = 8'hA5;
                dif.B     = 8'h5A;
            end
            if (dif.busy) bc++;
        end
        check("busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        dif.start = 1'b0;
        dif.A     = 8'h00;
        dif.B     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_P", 32'(dif.P), 32'd0);
        check("reset_busy", 32'(dif.busy), 32'd0);
        check("reset_done", 32'(dif.done), 32'd0);

        // Reset and start together: reset must win.
        dif.start = 1'b1;
        dif.A     = 8'd9;
        dif.B     = 8'd9;
        @(negedge clk);
        check("rst_beats_start_busy", 32'(dif.busy), 32'd0);
        dif.start = 1'b0;
        rst       = 1'b0;

        issue(8'd13,  8'd11,  16'h008F);
        issue(8'd255, 8'd255, 16'hFE01);
        issue(8'd0,   8'd200, 16'h0000);
        issue(8'd200, 8'd0,   16'h0000);

        // Start re-pulsed during RUN must be ignored.
        @(negedge clk);
        dif.A     = 8'd7;
        dif.B     = 8'd9;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{p: 16'h003F, due: cyc + 8});
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dif.A     = 8'd100;
        dif.B     = 8'd100;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored_start_idle", 32'(dif.busy), 32'd0);
        issue(8'd3, 8'd5, 16'h000F);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clk);
        dif.A     = 8'd50;
        dif.B     = 8'd3;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("busy_before_abort", 32'(dif.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_P", 32'(dif.P), 32'd0);
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_done", 32'(dif.done), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_P_held", 32'(dif.P), 32'd0);
        issue(8'd1, 8'd255, 16'h00FF);

        // Start held high: second multiply accepted 10 cycles after the first.
        @(negedge clk);
        dif.A     = 8'd2;
        dif.B     = 8'd3;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{p: 16'd6,  due: cyc + 8});
        exp_q.push_back('{p: 16'd20, due: cyc + 18});
        @(negedge clk);
        dif.A = 8'd4;
        dif.B = 8'd5;
        repeat (10) @(negedge clk);
        dif.start = 1'b0;
        repeat (10) @(negedge clk);
        check("p_held_after_done", 32'(dif.P), 32'd20);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 8x8 unsigned multiplier built around the existing eight_bit_adder.
- Sits directly downstream of the adder: consumes its R and C_out each cycle and feeds the partial sum back as the next addend.
- One add/shift per cycle; a 16-bit product is ready after 8 iterations.
- Start/done handshake lets a controller or testbench issue back-to-back multiplies.

Parameters:
- WIDTH, 8, operand width. 8 is the only supported value because the adder is fixed at 8 bits; the product is 2*WIDTH.
- ITER, WIDTH, number of add/shift iterations; equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- A  input  8  multiplicand, captured on an accepted start
- B  input  8  multiplier, captured on an accepted start
- P  output  16  product; updated only on completion, held otherwise
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  single-cycle pulse; P is valid in that cycle

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset (synchronous, rst high at a rising edge):
  - state=IDLE, P=0, busy=0, done=0.
  - mcand, hi, lo, count all cleared.
  - Reset mid-RUN aborts the operation: no done pulse, P=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - mcand<=A, lo<=B, hi<=0, count<=0, go to RUN.
  - busy=1 from the cycle after edge N.
- IDLE, start=0: stay in IDLE. P keeps its last value.
- RUN, each edge:
  - Adder inputs: first operand is hi; second operand is mcand if lo[0]=1, else 8'h00.
  - Update: {hi,lo} <= {C_out, R, lo[7:1]}, i.e. the 9-bit sum concatenated with lo shifted right by one.
  - count<=count+1.
  - On the edge where count==7 (the 8th iteration): P<={new hi,new lo}, go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge returns to IDLE.
- Latency: start accepted at edge N gives done=1 and P valid in the cycle after edge N+8. Issue interval is 10 cycles.
- start while in RUN or DONE is ignored. A and B are not re-sampled, and no queueing occurs.
- A and B may change freely after the accepting edge.
- Arithmetic:
  - All unsigned.
  - C_out is never lost; it shifts into hi[7].
  - The maximum 255*255=0xFE01 fits in 16 bits, so no overflow is possible.
- Zero operands take the full 8 iterations; there is no early termination.
- rst and start both high at the same edge: reset wins.

Decomposition:
- Shared include file (same style as one_bit_adder.v inclusion) holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH and ITER constants
- One sub-module instance: eight_bit_adder (existing, unchanged), driven combinationally from hi and the gated mcand.
- Everything else (control FSM, count, hi/lo/mcand/P registers) lives in shift_add_multiplier.

Test Plan:
- Reset, then A=13, B=11, start pulse → busy high 8 cycles, then done pulse with P=16'h008F (143), busy low.
- A=255, B=255 → P=16'hFE01 (65025); exercises C_out propagation into hi[7] every iteration.
- A=0, B=200 and A=200, B=0 → P=0 each time, done still arrives exactly 9 cycles after the accepting edge.
- Start accepted with A=7, B=9; re-pulse start with A=100, B=100 at cycle 3 of RUN → ignored, P=16'h003F. The next multiply issued from IDLE works normally.
- Start with A=50, B=3; assert rst at cycle 4 of RUN → no done pulse, P=0, busy=0, state IDLE. A subsequent A=1, B=255 gives P=16'h00FF.
- Back-to-back: hold start high continuously with A=2, B=3 then A=4, B=5 → products 6 and 20. Done pulses are 10 cycles apart, and each start is accepted only in IDLE.
